// File: rtl/jtframe_rom_arbiter_if.sv
// Bundle between the ROM slot clients and the SDRAM read port.
// master: the arbiter's view. slave: the clients' and SDRAM controller's view.
interface jtframe_rom_arbiter_if #(
    parameter int CHANNELS = 4,
    parameter int AW       = 22,
    parameter int DW       = 32
);
    logic [CHANNELS-1:0]    ch_req;
    logic [CHANNELS*AW-1:0] ch_addr;
    logic [CHANNELS-1:0]    ch_ok;
    logic [CHANNELS*DW-1:0] ch_data;
    logic                   sdram_req;
    logic                   sdram_ack;
    logic [AW-1:0]          sdram_addr;
    logic [DW-1:0]          data_read;
    logic                   data_rdy;
    logic                   busy;

    modport master (
        input  ch_req, ch_addr, sdram_ack, data_read, data_rdy,
        output ch_ok, ch_data, sdram_req, sdram_addr, busy
    );

    modport slave (
        output ch_req, ch_addr, sdram_ack, data_read, data_rdy,
        input  ch_ok, ch_data, sdram_req, sdram_addr, busy
    );
endinterface

// File: rtl/jtframe_rom_arbiter.sv
// Round-robin N-channel ROM read arbiter in front of one SDRAM read port.
// Ports: clk_rom, rst (async, active high), loop_rst (sync idle/flush),
//   bus (master): ch_req/ch_addr in, ch_ok/ch_data out per channel;
//   sdram_req/sdram_addr out, sdram_ack/data_read/data_rdy in; busy out.
// JTFRAME_ROMARB_CACHE_EN: keep per-channel data valid after the request
//   drops so a repeat read of the same address skips SDRAM.
module jtframe_rom_arbiter #(
    parameter int CHANNELS = 4,
    parameter int AW       = 22,
    parameter int DW       = 32
) (
    input  logic clk_rom,
    input  logic rst,
    input  logic loop_rst,
    jtframe_rom_arbiter_if.master bus
);
    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    state_t              r_state, w_state_nx;
    logic [GW-1:0]       r_gnt, w_gnt_nx;
    logic [GW-1:0]       r_rr, w_rr_nx;
    logic                r_sreq, w_sreq_nx;
    logic [AW-1:0]       r_saddr, w_saddr_nx;
    logic                w_done;

    logic [CHANNELS-1:0] r_valid;
    logic [CHANNELS-1:0] r_ok;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_pend;
    logic [CHANNELS-1:0] w_cand;
    logic [AW-1:0]       r_tag  [CHANNELS];
    logic [DW-1:0]       r_data [CHANNELS];

    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic [AW-1:0]       w_pick_addr;
    int                  w_idx;

    logic [CHANNELS*DW-1:0] w_chdata;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_hit[i] = r_valid[i] &&
                       (r_tag[i] == bus.ch_addr[i*AW +: AW]);
        end
    end

    assign w_pend = bus.ch_req & ~w_hit;

    // Registered pending gives the one-cycle request qualification;
    // the live term drops channels whose request went away meanwhile.
    assign w_cand = r_pend & w_pend;

    always_comb begin
        w_found     = 1'b0;
        w_pick      = '0;
        w_pick_addr = '0;
        w_idx       = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
            if (!w_found && w_cand[w_idx]) begin
                w_found     = 1'b1;
                w_pick      = GW'(w_idx);
                w_pick_addr = bus.ch_addr[w_idx*AW +: AW];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_rr_nx    = r_rr;
        w_sreq_nx  = r_sreq;
        w_saddr_nx = r_saddr;
        w_done     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nx   = w_pick;
                    w_saddr_nx = w_pick_addr;
                    w_sreq_nx  = 1'b1;
                    w_state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.sdram_ack) begin
                    w_sreq_nx = 1'b0;
                    if (bus.data_rdy) begin
                        w_done     = 1'b1;
                        w_rr_nx    = r_gnt;
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (bus.data_rdy) begin
                    w_done     = 1'b1;
                    w_rr_nx    = r_gnt;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_sreq_nx  = 1'b0;
                w_state_nx = IDLE;
            end
        endcase
        // Controller init abandons any transaction; rr survives.
        if (loop_rst) begin
            w_state_nx = IDLE;
            w_sreq_nx  = 1'b0;
            w_done     = 1'b0;
            w_gnt_nx   = r_gnt;
            w_rr_nx    = r_rr;
            w_saddr_nx = r_saddr;
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_rr    <= GW'(CHANNELS - 1);
            r_sreq  <= 1'b0;
            r_saddr <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_rr    <= w_rr_nx;
            r_sreq  <= w_sreq_nx;
            r_saddr <= w_saddr_nx;
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_ok    <= '0;
            r_pend  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (loop_rst) begin
            r_valid <= '0;
            r_ok    <= '0;
            r_pend  <= '0;
        end else begin
            r_ok   <= bus.ch_req & w_hit;
            r_pend <= w_pend;
`ifdef JTFRAME_ROMARB_CACHE_EN
`else
            r_valid <= r_valid & bus.ch_req;
`endif
            if (w_done) begin
                r_valid[r_gnt] <= 1'b1;
                r_tag[r_gnt]   <= r_saddr;
                r_data[r_gnt]  <= bus.data_read;
                // the returning channel's stale pending must not regrant
                r_pend[r_gnt]  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_chdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_chdata[i*DW +: DW] = r_data[i];
        end
    end

    assign bus.ch_data    = w_chdata;
    assign bus.ch_ok      = r_ok;
    assign bus.sdram_req  = r_sreq;
    assign bus.sdram_addr = r_saddr;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_jtframe_rom_arbiter.sv
// Directed bench for jtframe_rom_arbiter (4 channels, AW=22, DW=32).
// Acts as ROM clients and SDRAM controller; checks grant order and data.
module tb_jtframe_rom_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    jtframe_rom_arbiter_if #(.CHANNELS(4), .AW(22), .DW(32)) bus ();

    jtframe_rom_arbiter #(.CHANNELS(4), .AW(22), .DW(32)) dut (
        .clk_rom  (clk),
        .rst      (rst),
        .loop_rst (loop_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (bus.sdram_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " req"}, 64'(bus.sdram_req), 64'd1);
    endtask

    // ad: cycles before ack; rd: cycles from ack to data_rdy (0 = same)
    task automatic serve(input string tag, input logic [21:0] ea,
                         input int ad, input int rd, input logic [31:0] d);
        wait_req(tag);
        chk({tag, " addr"}, 64'(bus.sdram_addr), 64'(ea));
        repeat (ad) tick();
        chk({tag, " hold"}, 64'(bus.sdram_req), 64'd1);
        bus.sdram_ack = 1'b1;
        if (rd == 0) begin
            bus.data_rdy  = 1'b1;
            bus.data_read = d;
        end
        tick();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        if (rd > 0) begin
            chk({tag, " req drop"}, 64'(bus.sdram_req), 64'd0);
            repeat (rd - 1) tick();
            bus.data_rdy  = 1'b1;
            bus.data_read = d;
            tick();
            bus.data_rdy  = 1'b0;
        end
    endtask

    function automatic logic [31:0] dv(input logic [21:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    initial begin
        bus.ch_req    = '0;
        bus.ch_addr   = '0;
        bus.sdram_ack = 1'b0;
        bus.data_read = '0;
        bus.data_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req", 64'(bus.sdram_req), 64'd0);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst ok", 64'(bus.ch_ok), 64'd0);
        chk("rst addr", 64'(bus.sdram_addr), 64'd0);
        rst = 1'b0;
        tick();

        // single request with latency check
        bus.ch_addr[0 +: 22] = 22'h00123;
        bus.ch_req[0] = 1'b1;
        tick();
        chk("lat1 req", 64'(bus.sdram_req), 64'd0);
        tick();
        chk("lat2 req", 64'(bus.sdram_req), 64'd1);
        chk("lat2 busy", 64'(bus.busy), 64'd1);
        serve("single", 22'h00123, 2, 5, 32'hDEADBEEF);
        chk("single ok early", 64'(bus.ch_ok[0]), 64'd0);
        tick();
        chk("single ok", 64'(bus.ch_ok[0]), 64'd1);
        chk("single data", 64'(bus.ch_data[0 +: 32]), 64'hDEADBEEF);
        chk("single busy", 64'(bus.busy), 64'd0);
        chk("single idle", 64'(bus.sdram_req), 64'd0);
        bus.ch_req = '0;
        tick();

        // fresh reset, all four channels at once
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.ch_addr[0*22 +: 22] = 22'h10;
        bus.ch_addr[1*22 +: 22] = 22'h20;
        bus.ch_addr[2*22 +: 22] = 22'h30;
        bus.ch_addr[3*22 +: 22] = 22'h40;
        bus.ch_req = 4'hF;
        serve("rr0", 22'h10, 1, 2, dv(22'h10));
        serve("rr1", 22'h20, 0, 0, dv(22'h20));
        serve("rr2", 22'h30, 1, 1, dv(22'h30));
        serve("rr3", 22'h40, 0, 3, dv(22'h40));
        tick();
        chk("rr ok", 64'(bus.ch_ok), 64'hF);
        chk("rr d0", 64'(bus.ch_data[0*32 +: 32]), 64'(dv(22'h10)));
        chk("rr d1", 64'(bus.ch_data[1*32 +: 32]), 64'(dv(22'h20)));
        chk("rr d2", 64'(bus.ch_data[2*32 +: 32]), 64'(dv(22'h30)));
        chk("rr d3", 64'(bus.ch_data[3*32 +: 32]), 64'(dv(22'h40)));
        bus.ch_req = '0;
        tick();
        tick();
        chk("drop ok", 64'(bus.ch_ok), 64'd0);
        bus.ch_addr[0*22 +: 22] = 22'h60;
        bus.ch_addr[1*22 +: 22] = 22'h50;
        bus.ch_req = 4'b0011;
        serve("wrap0", 22'h60, 0, 1, dv(22'h60));
        serve("wrap1", 22'h50, 1, 2, dv(22'h50));
        tick();
        chk("wrap ok", 64'(bus.ch_ok), 64'h3);
        bus.ch_req = '0;
        tick();

        // channel 2 moves its address while its read is outstanding
        bus.ch_addr[2*22 +: 22] = 22'h100;
        bus.ch_req[2] = 1'b1;
        wait_req("mv");
        chk("mv addr", 64'(bus.sdram_addr), 64'h100);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.ch_addr[2*22 +: 22] = 22'h104;
        tick();
        bus.data_read = 32'h1111_1111;
        bus.data_rdy  = 1'b1;
        tick();
        bus.data_rdy  = 1'b0;
        tick();
        chk("mv ok0", 64'(bus.ch_ok[2]), 64'd0);
        serve("mv2", 22'h104, 1, 1, 32'h2222_2222);
        chk("mv ok1", 64'(bus.ch_ok[2]), 64'd0);
        tick();
        chk("mv ok2", 64'(bus.ch_ok[2]), 64'd1);
        chk("mv data", 64'(bus.ch_data[2*32 +: 32]), 64'h2222_2222);
        bus.ch_req = '0;
        tick();

        // repeat read of the same address after a short drop
        bus.ch_addr[3*22 +: 22] = 22'h200;
        bus.ch_req[3] = 1'b1;
        serve("c1", 22'h200, 0, 2, 32'h3333_3333);
        tick();
        chk("c1 ok", 64'(bus.ch_ok[3]), 64'd1);
        bus.ch_req[3] = 1'b0;
        tick();
        tick();
        chk("c drop ok", 64'(bus.ch_ok[3]), 64'd0);
        bus.ch_req[3] = 1'b1;
        tick();
`ifdef JTFRAME_ROMARB_CACHE_EN
        chk("c hit ok", 64'(bus.ch_ok[3]), 64'd1);
        repeat (3) tick();
        chk("c hit nosd", 64'(bus.sdram_req), 64'd0);
        chk("c hit busy", 64'(bus.busy), 64'd0);
`else
        chk("c miss ok", 64'(bus.ch_ok[3]), 64'd0);
        serve("c2", 22'h200, 0, 1, 32'h4444_4444);
        tick();
        chk("c2 ok", 64'(bus.ch_ok[3]), 64'd1);
        chk("c2 data", 64'(bus.ch_data[3*32 +: 32]), 64'h4444_4444);
`endif

        // loop_rst during WAIT_ACK, ch3 keeps requesting 0x200
        bus.ch_addr[1*22 +: 22] = 22'h300;
        bus.ch_req[1] = 1'b1;
        wait_req("lr");
        chk("lr addr", 64'(bus.sdram_addr), 64'h300);
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        chk("lr req", 64'(bus.sdram_req), 64'd0);
        chk("lr ok", 64'(bus.ch_ok), 64'd0);
        chk("lr busy", 64'(bus.busy), 64'd0);
        bus.data_read = 32'hBAD0_BAD0;
        bus.data_rdy  = 1'b1;
        tick();
        bus.data_rdy  = 1'b0;
        chk("lr late", 64'(bus.ch_data[1*32 +: 32]), 64'(dv(22'h50)));
        chk("lr idle", 64'(bus.busy), 64'd0);
        serve("lr1", 22'h300, 0, 1, 32'h5555_5555);
        serve("lr3", 22'h200, 1, 0, 32'h6666_6666);
        tick();
        chk("lr ok2", 64'(bus.ch_ok), 64'hA);
        chk("lr d1", 64'(bus.ch_data[1*32 +: 32]), 64'h5555_5555);
        chk("lr d3", 64'(bus.ch_data[3*32 +: 32]), 64'h6666_6666);

        // asynchronous reset while sdram_req is high
        bus.ch_req = '0;
        tick();
        bus.ch_addr[0*22 +: 22] = 22'h400;
        bus.ch_req[0] = 1'b1;
        wait_req("ar");
        chk("ar addr", 64'(bus.sdram_addr), 64'h400);
        #3;
        rst = 1'b1;
        #1;
        chk("ar req", 64'(bus.sdram_req), 64'd0);
        chk("ar busy", 64'(bus.busy), 64'd0);
        chk("ar ok", 64'(bus.ch_ok), 64'd0);
        chk("ar addr0", 64'(bus.sdram_addr), 64'd0);
        chk("ar data", 64'(|bus.ch_data), 64'd0);
        bus.ch_req = '0;
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
